serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder. Adds two WIDTH-bit operands LSB-first, one bit per clock.
- Built around a single full_adder_1b cell with a registered carry fed back between bits.
- Sits between operand registers and the result display/compare logic in the lab adder datapath.
- Trades WIDTH cycles of latency for one full-adder cell.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, 3, bit counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled on rising edge
- a  input  WIDTH  operand A; captured on the accepting edge only
- b  input  WIDTH  operand B; captured on the accepting edge only
- cin  input  1  carry-in; captured on the accepting edge only
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; held until the next result
- cout  output  1  registered carry-out of the MSB; held with sum

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flip-flop and counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load A shift reg<=a, B shift reg<=b, carry FF<=cin, cnt<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - Full-add of A[0], B[0] and carry FF.
  - Sum bit shifts into the MSB of the internal sum shift reg; A and B shift right by 1; carry FF<=full-adder cout; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge (last bit): result reg sum<=final shifted value, cout<=final carry; go to DONE.
- Latency: start sampled at edge k → RUN occupies edges k+1..k+WIDTH → done=1 in the cycle after edge k+WIDTH.
  - Exactly WIDTH processing edges; no extra pipeline stage.
- DONE (done=1, busy=0, exactly one cycle):
  - Next edge with start=0: go to IDLE.
  - Next edge with start=1: accept a new operation (load as in IDLE) and go directly to RUN; done drops.
- start while in RUN: ignored. No effect on operands, carry or count.
- a, b and cin may change freely after the accepting edge without affecting the result in progress.
- sum and cout change only on the RUN→DONE edge or on reset. They are stable during a subsequent RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Reset mid-RUN: operation aborted immediately; all outputs return to reset values; no done pulse.
- Counter wrap: cnt never exceeds WIDTH-1; it is reloaded to 0 on every accept.

Test Plan:
- Reset then start with a=8'h5A, b=8'h3C, cin=0 → busy high 8 cycles; done pulses once 8 edges after the accepting edge; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Start a=8'h12, b=8'h34; during RUN hold start=1 and change a/b to 8'hFF each cycle → ignored; sum=8'h46, cout=0; exactly one done pulse.
- Assert start in the DONE cycle with a=8'h01, b=8'h01, cin=1 → first result still held; new RUN begins with no IDLE cycle; next done gives sum=8'h03, cout=0. Previous sum stays stable until then.
- Drop rst_n asynchronously at RUN cycle 4 of 8'hAA+8'h55 → busy, done, sum and cout go to 0 immediately. After release, a fresh 8'hAA+8'h55 gives sum=8'hFF, cout=0.
- WIDTH=4 instance: a=4'hF, b=4'hF, cin=1 → done after 4 processing edges; sum=4'hF, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder
// cell, with the carry held in a flip-flop between bits.

module full_adder_1b (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       o_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sh_next;

  full_adder_1b u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // A new operation can be accepted from IDLE or straight out of DONE.
  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_state == RUN) && (r_cnt == LAST);
  assign w_sh_next = {w_fa_s, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = (r_cnt == LAST) ? DONE : RUN;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == RUN);
    done    = (r_state == DONE);
    o_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_fa_c;
      r_sh    <= w_sh_next;
      // Counter holds at WIDTH-1 on the last bit; it is reloaded on accept.
      if (w_last) begin
        r_sum  <= w_sh_next;
        r_cout <= w_fa_c;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vectors, expected {cout,sum} queued at issue
// and checked by a monitor on every done pulse; a WIDTH=4 instance runs too.

module tb_serial_adder;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic [1:0] st;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;
  logic [1:0] st4;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] held;

  serial_adder #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .o_state(st)
  );

  serial_adder #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .o_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL w8_result: unexpected done, got %0h expected none", {cout, sum});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL w8_result: got %0h expected %0h", {cout, sum}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL w4_result: unexpected done, got %0h expected none", {cout4, sum4});
      end else begin
        logic [4:0] e;
        e = exp4_q.pop_front();
        if ({cout4, sum4} !== e) begin
          errors++;
          $display("FAIL w4_result: got %0h expected %0h", {cout4, sum4}, e);
        end
      end
    end
  end

  // driver tasks: issue drives start at a negedge; run_body waits out the op
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [8:0] expv);
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    exp_q.push_back(expv);
  endtask

  task automatic run_body(input bit junk, input logic [8:0] expv);
    @(posedge clk);
    #1;
    start = junk;
    a = 8'(~a);
    b = 8'(~b);
    cin = ~cin;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_run", {31'd0, done}, 32'd0);
      check("held_sum", {23'd0, cout, sum}, {23'd0, held});
      if (junk) begin
        a = 8'hFF;
        b = 8'hFF;
        start = (i < 7);
      end
    end
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    held = expv;
  endtask

  task automatic idle_after;
    start = 1'b0;
    @(negedge clk);
    check("done_once", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    held = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", {23'd0, cout, sum}, 32'd0);
    check("rst_state", {30'd0, st}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h5A, 8'h3C, 1'b0, 9'h096);
    run_body(1'b0, 9'h096);
    idle_after();

    @(negedge clk);
    issue(8'hFF, 8'h01, 1'b0, 9'h100);
    run_body(1'b0, 9'h100);
    idle_after();

    issue(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    run_body(1'b0, 9'h1FF);
    idle_after();

    // start held and operands scrambled during RUN must be ignored
    issue(8'h12, 8'h34, 1'b0, 9'h046);
    run_body(1'b1, 9'h046);
    idle_after();

    // back-to-back: accept in the DONE cycle
    issue(8'h0F, 8'h0F, 1'b0, 9'h01E);
    run_body(1'b0, 9'h01E);
    issue(8'h01, 8'h01, 1'b1, 9'h003);
    run_body(1'b0, 9'h003);
    idle_after();

    // asynchronous reset in the middle of a run
    issue(8'hAA, 8'h55, 1'b0, 9'h0FF);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_res", {23'd0, cout, sum}, 32'd0);
    void'(exp_q.pop_back());
    held = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {31'd0, done}, 32'd0);
    issue(8'hAA, 8'h55, 1'b0, 9'h0FF);
    run_body(1'b0, 9'h0FF);
    idle_after();

    // WIDTH=4 instance
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    exp4_q.push_back(5'h1F);
    @(posedge clk);
    #1 start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("w4_busy", {31'd0, busy4}, 32'd1);
    end
    @(negedge clk);
    check("w4_done", {31'd0, done4}, 32'd1);
    @(negedge clk);
    check("w4_done_once", {31'd0, done4}, 32'd0);

    repeat (2) @(negedge clk);
    check("w8_queue_empty", exp_q.size(), 32'd0);
    check("w4_queue_empty", exp4_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
